ovl_fire_arbiter: RTL and testbench
===================================

# ovl_fire_arbiter

Collects fire pulses from up to NUM_SRC OVL checker instances (ovl_implication and siblings) and serialises them onto one valid/ready report channel with round-robin fairness. Each source has a pending-fire counter, so no fire is lost while the report channel is stalled. The block sits between the checker instances in a test top and the bench's logging/scoreboard component. It replaces per-checker polling.

## Interface
- NUM_SRC, default 4: number of checker fire inputs (2..16)
- CNT_W, default 8: width of each pending-fire counter and of rpt_count
- SRC_W, default $clog2(NUM_SRC): width of rpt_src (derived, not overridden)

- clock  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-low; sampled on posedge clock
- enable  input  1  1 = accept fire_in; 0 = ignore fire_in, pending counts and reporting continue
- fire_in  input  NUM_SRC  bit i = checker i fired this cycle (level sampled per cycle)
- rpt_valid  output  1  report held on rpt_* outputs
- rpt_ready  input  1  consumer accepts report when rpt_valid & rpt_ready at posedge
- rpt_src  output  SRC_W  index of reporting checker
- rpt_count  output  CNT_W  fires accumulated by that checker since its last report (>=1)
- rpt_ovf  output  1  that checker's counter saturated before this report
- busy  output  1  any counter nonzero or rpt_valid high

## Operation
- Per source i: cnt[i] (CNT_W), ovf[i]. At posedge, if enable & fire_in[i]: cnt[i] += 1, saturating at 2^CNT_W-1; a fire arriving while saturated sets ovf[i].
- Pending[i] = (cnt[i] != 0).
- States: IDLE (rpt_valid=0), HOLD (rpt_valid=1).
- Load condition: (state==IDLE, or HOLD with rpt_valid & rpt_ready) and any pending. On load, choose winner w = first pending index strictly after last_grant, wrapping modulo NUM_SRC. Latch rpt_src=w, rpt_count=cnt[w], rpt_ovf=ovf[w]. Set last_grant=w. Enter/stay in HOLD.
- Winner clear-and-add: on load, cnt[w] becomes (enable & fire_in[w]) ? 1 : 0. ovf[w] clears. A same-cycle fire is never lost.
- HOLD with no handshake: rpt_* stay stable. Counters keep accumulating.
- HOLD with handshake and nothing pending: go to IDLE. rpt_valid=0 next cycle.
- Back-to-back: handshake plus pending gives a new report in the next cycle with no bubble.
- rpt_ready is ignored in IDLE.
- Reset (reset==0 at posedge): all cnt, ovf and rpt_* cleared to 0. last_grant=NUM_SRC-1, so source 0 has priority first. State=IDLE. This applies mid-HOLD too: the held report is discarded and rpt_valid drops at that edge.
- enable low during HOLD has no effect on the held report.

## Timing
- Reset values: rpt_valid=0, rpt_src=0, rpt_count=0, rpt_ovf=0, busy=0.
- Latency: fire sampled at edge k (IDLE, no other pending) -> cnt=1 after edge k -> rpt_valid=1 after edge k+1. Two-edge fire-to-report latency.
- Throughput: one report per cycle while rpt_ready is held high.
- Fairness: with all sources continuously pending, grants rotate 0,1,..,NUM_SRC-1,0. A source waits at most NUM_SRC-1 reports.
- All outputs are registered except busy, which is combinational from registers only.

## Structure
- Package ovl_fire_arb_pkg holds:
  - typedef enum logic {IDLE, HOLD} arb_state_t
  - the MAX_SRC=16 constant
  - a function for the saturating increment
- Sub-module ovl_rr_pick: combinational round-robin picker. Inputs are req[NUM_SRC] and last[SRC_W]; outputs are gnt_idx and any. Instantiated once.
- Top contains the counters, state register and output registers. Clock comes from the existing ivl_uvm_ovl_clk_gen in benches.

## Test plan
- Reset hold: reset=0 for 3 cycles with fire_in=4'hF -> rpt_valid=0, busy=0 throughout; first report after release is src 0.
- Single fire: fire_in=4'b0100 for 1 cycle, rpt_ready=1 -> rpt_valid high for exactly 1 cycle, 2 edges later; rpt_src=2, rpt_count=1, rpt_ovf=0.
- Stall accumulation: rpt_ready=0, fire_in[1]=1 for 10 cycles, then rpt_ready=1 -> first report src 1 count 1 (latched at first load), second report src 1 count 9.
- Round-robin: fire_in=4'hF for 1 cycle, rpt_ready=1 -> reports src 0,1,2,3 back-to-back, each count 1, then rpt_valid=0.
- Saturation (CNT_W=4): 20 fires on src 3 while stalled -> report count 15, rpt_ovf=1; the next fire reports count 1, rpt_ovf=0.
- Mid-operation reset and enable: reset low while rpt_valid=1 -> rpt_valid=0 after that edge, no residual reports. enable=0 with fire_in=4'hF -> no reports.

Source files
------------

// File: rtl/ovl_fire_arb_pkg.sv
// Shared types and helpers for the OVL fire arbiter.
// Holds the arbiter state type, source limit and saturating-count step.
package ovl_fire_arb_pkg;

  typedef enum logic {IDLE, HOLD} arb_state_t;

  localparam int MAX_SRC = 16;

  function automatic logic sat_step(
    input logic fire,
    input logic full
  );
    return fire & ~full;
  endfunction

endpackage

// File: rtl/ovl_rr_pick.sv
// Combinational round-robin picker: first requester
// strictly after the last grant, wrapping modulo NUM_SRC.
module ovl_rr_pick
  import ovl_fire_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int SRC_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               any
);

  int idx;
  logic [SRC_W-1:0] idx_w;

  // Walk offsets high to low so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    any     = |req;
    idx     = 0;
    idx_w   = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx   = (int'(last) + k) % NUM_SRC;
      idx_w = SRC_W'(idx);
      if (req[idx_w]) gnt_idx = idx_w;
    end
  end

endmodule

// File: rtl/ovl_fire_arbiter.sv
// Serialises OVL checker fire pulses onto one valid/ready
// report channel with per-source pending counters.
module ovl_fire_arbiter
  import ovl_fire_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 8,
  localparam int SRC_W  = $clog2(NUM_SRC)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] fire_in,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [SRC_W-1:0]   rpt_src,
  output logic [CNT_W-1:0]   rpt_count,
  output logic               rpt_ovf,
  output logic               busy
);

  if (NUM_SRC < 2 || NUM_SRC > MAX_SRC) begin : g_bad_cfg
    $error("ovl_fire_arbiter: NUM_SRC out of range");
  end

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_SRC];
  logic [CNT_W-1:0] cnt_d [NUM_SRC];
  logic [NUM_SRC-1:0] ovf_q, ovf_d;
  logic [SRC_W-1:0] last_q, last_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rovf_q, rovf_d;

  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] fire;
  logic [SRC_W-1:0]   gnt;
  logic               any;
  logic               load;

  always_comb begin
    fire = fire_in & {NUM_SRC{enable}};
    for (int i = 0; i < NUM_SRC; i++) pend[i] = |cnt_q[i];
  end

  ovl_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req     (pend),
    .last    (last_q),
    .gnt_idx (gnt),
    .any     (any)
  );

  // In HOLD the report is always valid, so ready alone is the handshake.
  assign load = any & ((state_q == IDLE) | rpt_ready);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    src_d   = src_q;
    count_d = count_q;
    rovf_d  = rovf_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < NUM_SRC; i++) cnt_d[i] = cnt_q[i];

    for (int i = 0; i < NUM_SRC; i++) begin
      if (load && gnt == SRC_W'(i)) begin
        cnt_d[i] = {{(CNT_W-1){1'b0}}, fire[i]};
        ovf_d[i] = 1'b0;
      end else begin
        if (sat_step(fire[i], &cnt_q[i]))
          cnt_d[i] = cnt_q[i] + 1'b1;
        if (fire[i] && &cnt_q[i])
          ovf_d[i] = 1'b1;
      end
    end

    if (load) begin
      state_d = HOLD;
      last_d  = gnt;
      src_d   = gnt;
      count_d = cnt_q[gnt];
      rovf_d  = ovf_q[gnt];
    end else if (state_q == HOLD && rpt_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= SRC_W'(NUM_SRC - 1);
      src_q   <= '0;
      count_q <= '0;
      rovf_q  <= 1'b0;
      ovf_q   <= '0;
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      count_q <= count_d;
      rovf_q  <= rovf_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rpt_valid = (state_q == HOLD);
  assign rpt_src   = src_q;
  assign rpt_count = count_q;
  assign rpt_ovf   = rovf_q;
  assign busy      = (|pend) | rpt_valid;

endmodule

// File: tb/tb_ovl_fire_arbiter.sv
// Directed bench for ovl_fire_arbiter with a per-cycle
// reference model and literal report-log checks.
module tb_ovl_fire_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int SATMAX = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          enable;
  logic [N-1:0]  fire_in;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [1:0]    rpt_src;
  logic [CW-1:0] rpt_count;
  logic          rpt_ovf;
  logic          busy;

  ovl_fire_arbiter #(.NUM_SRC(N), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .fire_in   (fire_in),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_src   (rpt_src),
    .rpt_count (rpt_count),
    .rpt_ovf   (rpt_ovf),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending counts per source and the held report.
  int m_cnt [N];
  bit m_sat [N];
  bit m_valid;
  int m_src, m_count;
  bit m_ovf;
  int m_last;
  bit started = 0;

  always @(posedge clock) begin
    int w;
    bit take;
    started = 1;
    if (!reset) begin
      foreach (m_cnt[i]) begin m_cnt[i] = 0; m_sat[i] = 0; end
      m_valid = 0; m_src = 0; m_count = 0; m_ovf = 0;
      m_last = N - 1;
    end else begin
      w = -1;
      take = !m_valid || rpt_ready;
      if (take)
        for (int k = N; k >= 1; k--)
          if (m_cnt[(m_last + k) % N] > 0) w = (m_last + k) % N;
      if (w >= 0) begin
        m_valid = 1; m_src = w; m_count = m_cnt[w];
        m_ovf = m_sat[w]; m_last = w;
        m_cnt[w] = 0; m_sat[w] = 0;
      end else if (m_valid && rpt_ready) begin
        m_valid = 0;
      end
      for (int i = 0; i < N; i++)
        if (enable && fire_in[i]) begin
          if (i == w) m_cnt[i] = 1;
          else if (m_cnt[i] == SATMAX) m_sat[i] = 1;
          else m_cnt[i]++;
        end
    end
  end

  logic [6:0] rlog [$];

  always @(negedge clock) begin
    int pend;
    if (started) begin
      pend = 0;
      foreach (m_cnt[i]) if (m_cnt[i] > 0) pend = 1;
      chk("valid", int'(rpt_valid), int'(m_valid));
      chk("busy", int'(busy), (m_valid || pend) ? 1 : 0);
      if (m_valid) begin
        chk("src", int'(rpt_src), m_src);
        chk("count", int'(rpt_count), m_count);
        chk("ovf", int'(rpt_ovf), int'(m_ovf));
      end
      if (reset && rpt_valid && rpt_ready)
        rlog.push_back({rpt_src, rpt_count, rpt_ovf});
    end
  end

  task automatic cyc(input logic rst, input logic en,
                     input logic [N-1:0] f, input logic rdy);
    reset = rst; enable = en; fire_in = f; rpt_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_ent(input string nm, input int k,
                         input int s, input int c, input int o);
    int act;
    act = (k < rlog.size()) ? int'(rlog[k]) : -1;
    chk(nm, act, s * 32 + c * 2 + o);
  endtask

  initial begin
    reset = 0; enable = 1; fire_in = '0; rpt_ready = 1;

    repeat (3) begin
      cyc(0, 1, 4'hF, 1);
      chk("rst_valid", int'(rpt_valid), 0);
      chk("rst_busy", int'(busy), 0);
    end

    cyc(1, 1, 4'hF, 1);
    repeat (7) cyc(1, 1, 4'h0, 1);
    chk("rr_n", rlog.size(), 4);
    chk_ent("rr0", 0, 0, 1, 0);
    chk_ent("rr1", 1, 1, 1, 0);
    chk_ent("rr2", 2, 2, 1, 0);
    chk_ent("rr3", 3, 3, 1, 0);
    chk("rr_idle", int'(rpt_valid), 0);
    rlog.delete();

    cyc(1, 1, 4'b0100, 1);
    chk("one_lat1", int'(rpt_valid), 0);
    cyc(1, 1, 4'h0, 1);
    chk("one_lat2", int'(rpt_valid), 1);
    chk("one_src", int'(rpt_src), 2);
    cyc(1, 1, 4'h0, 1);
    chk("one_drop", int'(rpt_valid), 0);
    repeat (2) cyc(1, 1, 4'h0, 1);
    chk("one_n", rlog.size(), 1);
    chk_ent("one0", 0, 2, 1, 0);
    rlog.delete();

    repeat (10) cyc(1, 1, 4'b0010, 0);
    repeat (4) cyc(1, 1, 4'h0, 1);
    chk("stall_n", rlog.size(), 2);
    chk_ent("stall0", 0, 1, 1, 0);
    chk_ent("stall1", 1, 1, 9, 0);
    rlog.delete();

    repeat (20) cyc(1, 1, 4'b1000, 0);
    repeat (4) cyc(1, 1, 4'h0, 1);
    cyc(1, 1, 4'b1000, 1);
    repeat (3) cyc(1, 1, 4'h0, 1);
    chk("sat_n", rlog.size(), 3);
    chk_ent("sat0", 0, 3, 1, 0);
    chk_ent("sat1", 1, 3, 15, 1);
    chk_ent("sat2", 2, 3, 1, 0);
    rlog.delete();

    cyc(1, 1, 4'b0001, 0);
    repeat (2) cyc(1, 1, 4'h0, 0);
    chk("mid_hold", int'(rpt_valid), 1);
    cyc(0, 1, 4'h0, 0);
    chk("mid_rst_valid", int'(rpt_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    repeat (5) cyc(1, 1, 4'h0, 1);
    chk("mid_none", rlog.size(), 0);

    repeat (5) cyc(1, 0, 4'hF, 1);
    chk("en_none", rlog.size(), 0);
    chk("en_busy", int'(busy), 0);

    cyc(1, 1, 4'b0001, 0);
    cyc(1, 1, 4'h0, 0);
    repeat (3) cyc(1, 0, 4'hF, 0);
    chk("enh_valid", int'(rpt_valid), 1);
    chk("enh_src", int'(rpt_src), 0);
    chk("enh_count", int'(rpt_count), 1);
    repeat (3) cyc(1, 1, 4'h0, 1);
    chk("enh_n", rlog.size(), 1);
    chk_ent("enh0", 0, 0, 1, 0);
    chk("enh_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
